uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arb.sv | 136 +++++++++++++
 tb/tb_uart_tx_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// Optional packet lock is enabled by defining UART_TX_ARB_LOCK_EN.
package uart_tx_arb_pkg;

    localparam int unsigned DEF_N_REQ      = 4;
    localparam int unsigned DEF_STROBE_CYC = 4;
    localparam int unsigned DEF_FRAME_CYC  = 250;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the search starts one past the pointer
// and wraps, the first valid requester wins.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [2:0]       win_idx,
    output logic             any
);

    // Walk the requesters in rotated order and keep the first valid one
    always_comb begin
        logic [N_REQ-1:0] sel;
        int unsigned      cand;
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        sel        = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            sel  = N_REQ'(1) << cand;
            if (!any && ((valid & sel) != '0)) begin
                any        = 1'b1;
                win_onehot = sel;
                win_idx    = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one byte at a time to a UART transmitter.
// Each byte: one IDLE accept cycle, STROBE_CYC cycles of tx_send, then a
// FRAME_CYC gap while the UART shifts the frame out.
// Define UART_TX_ARB_LOCK_EN to keep a requester granted until it sends a
// byte marked req_last.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned FRAME_CYC  = DEF_FRAME_CYC
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int unsigned CNT_W = $clog2(FRAME_CYC + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       last_ptr;
    logic [N_REQ-1:0] arb_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [2:0]       pick_idx;
    logic             pick_any;
    logic [7:0]       sel_byte;
    logic             win_last;

`ifdef UART_TX_ARB_LOCK_EN
    logic       lock_act;
    logic [2:0] lock_id;

    // While a packet is open only its owner may be considered
    always_comb begin
        arb_valid = lock_act ? (req_valid & (N_REQ'(1) << lock_id)) : req_valid;
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    // Every byte arbitrates independently
    always_comb begin
        arb_valid = req_valid;
    end
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .valid      (arb_valid),
        .ptr        (last_ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .any        (pick_any)
    );

    // Winner's byte and last marker
    always_comb begin
        sel_byte = 8'(req_data >> {pick_idx, 3'b000});
        win_last = |(req_last & pick_onehot);
    end

    // Accept pulse lives in the IDLE cycle itself; the state already reads
    // IDLE while reset is held, so reset gates it explicitly
    always_comb begin
        req_ready = (sys_rst_n && (state == ST_IDLE) && pick_any) ? pick_onehot : '0;
    end

    // Byte sequencer: accept, strobe, frame gap
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            last_ptr <= 3'(N_REQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
            lock_act <= 1'b0;
            lock_id  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        tx_data  <= sel_byte;
                        grant_id <= pick_idx;
                        last_ptr <= pick_idx;
                        tx_send  <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_STROBE;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_act <= !win_last;
                        lock_id  <= pick_idx;
`endif
                    end
                end
                ST_STROBE: begin
                    if (cnt == CNT_W'(STROBE_CYC - 1)) begin
                        cnt     <= '0;
                        tx_send <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(FRAME_CYC - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    tx_send <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb at default parameters.
// Expected bytes are queued as stimulus is driven and compared when the
// DUT raises tx_send. Honours UART_TX_ARB_LOCK_EN for the packet test.
module tb_uart_tx_arb;

    localparam int unsigned N          = 4;
    localparam int unsigned STROBE_CYC = 4;
    localparam int unsigned FRAME_CYC  = 250;
    localparam int unsigned PERIOD     = 1 + STROBE_CYC + FRAME_CYC;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_send;
    logic [7:0]     tx_data;
    logic           busy;
    logic [2:0]     grant_id;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    uart_tx_arb #(
        .N_REQ      (N),
        .STROBE_CYC (STROBE_CYC),
        .FRAME_CYC  (FRAME_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 3'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (busy) check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    // Output monitor: scoreboard on each strobe, strobe width, data hold
    exp_t       mon_e;
    logic [7:0] mon_held = '0;
    logic       mon_prev_send = 1'b0;
    logic       mon_prev_busy = 1'b0;
    int         mon_hi = 0;

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (tx_send && !mon_prev_send) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_id", 32'(grant_id), 32'(mon_e.id));
                    check_eq("sb_data", 32'(tx_data), 32'(mon_e.data));
                end
                mon_held = tx_data;
                mon_hi   = 0;
            end
            if (tx_send) mon_hi++;
            if (!tx_send && mon_prev_send && sys_rst_n)
                check_eq("strobe_len", 32'(mon_hi), 32'(STROBE_CYC));
            if (!busy && mon_prev_busy && sys_rst_n)
                check_eq("data_hold", 32'(tx_data), 32'(mon_held));
            mon_prev_send = tx_send;
            mon_prev_busy = busy;
        end
    end

    initial begin
        int         n;
        int         k;
        int         last_i;
        int         i1;
        logic       seen;
        logic [N-1:0] rdy;
        logic       f_send, f_rdy, f_busy;

        sys_rst_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '1;
        #12;
        check_eq("rst_send", 32'(tx_send), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Single byte from requester 0
        @(posedge sys_clk);
        #1;
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'h55;
        push_exp(0, 8'h55);
        @(negedge sys_clk);
        check_eq("a_ready", 32'(req_ready), 32'b0001);
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        n = 1;
        check_eq("a_busy_on", 32'(busy), 32'd1);
        while (busy && n < 2000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check_eq("a_busy_len", 32'(n), 32'(PERIOD));

        // Reset again so the pointer starts at requester 0, then all four busy
        sys_rst_n = 1'b0;
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        push_exp(0, 8'hA0);
        push_exp(1, 8'hA1);
        push_exp(2, 8'hA2);
        push_exp(3, 8'hA3);
        push_exp(0, 8'hA0);
        req_valid = 4'b1111;
        k = 0;
        last_i = 0;
        for (int i = 0; i < 5 * int'(PERIOD) + 50 && k < 5; i++) begin
            @(negedge sys_clk);
            if (req_ready != '0) begin
                if (k > 0) check_eq("b_period", 32'(i - last_i), 32'(PERIOD));
                last_i = i;
                k++;
            end
            if (k == 5) begin
                @(posedge sys_clk);
                #1;
                req_valid = '0;
            end
        end
        check_eq("b_count", 32'(k), 32'd5);
        req_valid = '0;
        wait_idle();

        // Requester 2 appears during requester 0's gap
        @(posedge sys_clk);
        #1;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h10;
        push_exp(0, 8'h10);
        @(negedge sys_clk);
        check_eq("c_ready0", 32'(req_ready), 32'b0001);
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        repeat (10) @(posedge sys_clk);
        #1;
        req_valid      = 4'b0100;
        req_data[23:16] = 8'h22;
        push_exp(2, 8'h22);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (!busy) break;
            if (req_ready != '0) seen = 1'b1;
        end
        check_eq("c_no_early_ready", 32'(seen), 32'd0);
        check_eq("c_ready2", 32'(req_ready), 32'b0100);
        @(posedge sys_clk);
        #1;
        req_valid = '0;

        // Reset in the middle of the gap abandons the byte
        repeat (30) @(posedge sys_clk);
        #1;
        check_eq("d_in_gap", 32'({busy, tx_send}), 32'b10);
        sys_rst_n       = 1'b0;
        req_valid       = 4'b0101;
        req_data[7:0]   = 8'h30;
        req_data[23:16] = 8'h32;
        #1;
        check_eq("d_rst_send", 32'(tx_send), 32'd0);
        check_eq("d_rst_busy", 32'(busy), 32'd0);
        check_eq("d_rst_ready", 32'(req_ready), 32'd0);
        check_eq("d_rst_grant", 32'(grant_id), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        push_exp(0, 8'h30);
        @(negedge sys_clk);
        check_eq("d_ready0", 32'(req_ready), 32'b0001);
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Requester 1 sends a three-byte packet while requester 0 waits
        @(posedge sys_clk);
        #1;
        req_data[7:0]  = 8'h40;
        req_data[15:8] = 8'h41;
        req_last       = 4'b1101;
`ifdef UART_TX_ARB_LOCK_EN
        push_exp(1, 8'h41);
        push_exp(1, 8'h42);
        push_exp(1, 8'h43);
        push_exp(0, 8'h40);
`else
        push_exp(1, 8'h41);
        push_exp(0, 8'h40);
        push_exp(1, 8'h42);
        push_exp(1, 8'h43);
`endif
        req_valid = 4'b0011;
        i1 = 0;
        for (int c = 0; c < 6 * int'(PERIOD) && req_valid != '0; c++) begin
            @(negedge sys_clk);
            rdy = req_ready;
            @(posedge sys_clk);
            #1;
            if (rdy[0]) req_valid[0] = 1'b0;
            if (rdy[1]) begin
                i1++;
                if (i1 == 3) begin
                    req_valid[1] = 1'b0;
                end else begin
                    req_data[15:8] = 8'(8'h41 + i1);
                    req_last[1]    = (i1 == 2);
                end
            end
        end
        check_eq("e_done", 32'(req_valid), 32'd0);
        req_valid = '0;
        req_last  = '1;
        wait_idle();

        // Long idle with nothing requested
        f_send = 1'b0;
        f_rdy  = 1'b0;
        f_busy = 1'b0;
        repeat (1000) begin
            @(negedge sys_clk);
            f_send = f_send | tx_send;
            f_rdy  = f_rdy | (req_ready != '0);
            f_busy = f_busy | busy;
        end
        check_eq("f_send", 32'(f_send), 32'd0);
        check_eq("f_ready", 32'(f_rdy), 32'd0);
        check_eq("f_busy", 32'(f_busy), 32'd0);

        check_eq("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
